pipelined_mux_arbiter: RTL and testbench
========================================

PIPELINED_MUX_ARBITER -- requirements
Module: pipelined_mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of each input channel and of the output.
REQ-002 The block SHALL have parameter NUM_IN, default 4, number of input channels; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL derive SEL_W = log2(NUM_IN) internally; it is not user-settable.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = direct select, 1 = round-robin arbitration.
REQ-007 The block SHALL have port sel, input, SEL_W bits: channel index used in mode 0.
REQ-008 The block SHALL have port in_valid, input, NUM_IN bits: per-channel valid.
REQ-009 The block SHALL have port in_data, input, NUM_IN*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port in_ready, output, NUM_IN bits: per-channel ready.
REQ-011 The block SHALL have port out_valid, output, 1 bit: output register holds a beat.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-013 The block SHALL have port out_src, output, SEL_W bits: index of the channel that supplied out_data.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-015 The block SHALL have port xfer_count, output, 32 bits: count of completed output transfers.

Function
REQ-016 load_en SHALL equal (!out_valid || out_ready), combinationally.
REQ-017 Mode 0: in_ready[sel] SHALL equal load_en and all other in_ready bits SHALL be 0; a load occurs when in_valid[sel] && load_en.
REQ-018 Mode 1: the winner SHALL be the first k with in_valid[k]=1, searching ptr, ptr+1, ... modulo NUM_IN; in_ready[winner] SHALL equal load_en, all others 0; with no valid channel, in_ready SHALL be all 0.
REQ-019 On a load, out_data SHALL take the winning channel's data, out_src its index, and out_valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-020 In mode 1, on a load ptr SHALL become (winner+1) mod NUM_IN, wrapping from NUM_IN-1 to 0; without a load ptr SHALL hold; in mode 0 ptr SHALL hold.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_src and out_valid SHALL hold; mode/sel changes SHALL NOT alter the held beat.
REQ-022 When out_valid && out_ready and no new load occurs, out_valid SHALL go to 0; with a simultaneous load it SHALL stay 1 with the new beat (full throughput, one beat per cycle).
REQ-023 xfer_count SHALL increment by 1 on each cycle with out_valid && out_ready, wrapping 0xFFFFFFFF -> 0.
REQ-024 A mode switch SHALL take effect on the same cycle's selection; ptr SHALL retain its value across mode switches.

Reset
REQ-025 rst_n=0 SHALL immediately force out_valid=0, out_data=0, out_src=0, ptr=0, xfer_count=0, regardless of clk.
REQ-026 While rst_n=0, in_ready SHALL be all 0; after release, the first load SHALL occur no earlier than the first rising clk edge with rst_n=1.
REQ-027 Reset asserted mid-stall SHALL discard the held beat; it SHALL NOT be presented after release.

Verification
REQ-028 Mode 0, WIDTH=32, NUM_IN=4, in_data ch k = 2**k, sel sweeps 0..3, out_ready=1 -> out_data 1,2,4,8 each one cycle after selection, out_src = sel.
REQ-029 Mode 1, all in_valid=1, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles; xfer_count=5 after five beats.
REQ-030 Mode 1, in_valid=4'b1010, ptr=0 -> winner 1, then 3, then 1; ch 0 and 2 never see in_ready=1.
REQ-031 Beat from ch 2 loaded, out_ready=0 for 3 cycles while in_data[2] and sel change -> out_data/out_src unchanged, in_ready all 0; out_ready=1 -> transfer completes, xfer_count+1.
REQ-032 rst_n pulled low between clk edges while out_valid=1 -> out_valid, out_data, xfer_count read 0 before the next edge; no stale beat after release.
REQ-033 xfer_count preloaded near wrap by running 0xFFFFFFFF transfers (or forced) -> next transfer yields xfer_count=0.

Source files
------------

// File: rtl/pipelined_mux_arbiter.sv
// pipelined_mux_arbiter
//   Selects one of NUM_IN valid/ready input channels into a single registered
//   output stage. Mode 0 picks the channel given by sel; mode 1 arbitrates
//   round-robin starting at an internal pointer. One beat per cycle throughput.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   mode       : 0 = direct select, 1 = round-robin
//   sel        : channel index used in mode 0
//   in_valid   : per-channel valid
//   in_data    : channel k at [k*WIDTH +: WIDTH]
//   in_ready   : per-channel ready (only the selected/winning channel)
//   out_valid  : output register holds a beat
//   out_data   : registered selected data
//   out_src    : index of the channel that supplied out_data
//   out_ready  : downstream accepts the beat
//   xfer_count : number of completed output transfers (wraps)
module pipelined_mux_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [$clog2(NUM_IN)-1:0] sel,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  output logic [NUM_IN-1:0]         in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_IN)-1:0] out_src,
  input  logic                      out_ready,
  output logic [31:0]               xfer_count
);

  localparam int SEL_W = $clog2(NUM_IN);

  if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
    $error("NUM_IN must be a power of two and at least 2");
  end

  logic [SEL_W-1:0] ptr_q,       ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;
  logic [31:0]      xfer_count_q, xfer_count_d;

  logic             load_en;
  logic             load;
  logic             found;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] sel_idx;
  logic             sel_vld;

  always_comb begin
    load_en = !out_valid_q || out_ready;

    // Round-robin search; index arithmetic wraps for free because NUM_IN
    // is a power of two and idx is exactly SEL_W bits wide.
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      idx = ptr_q + SEL_W'(i);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    if (mode) begin
      sel_idx = win;
      sel_vld = found;
    end else begin
      sel_idx = sel;
      sel_vld = in_valid[sel];
    end

    // Mode 0 advertises ready on sel even without valid; mode 1 only on a winner.
    in_ready = '0;
    if (rst_n && (!mode || found)) begin
      in_ready[sel_idx] = load_en;
    end

    load = rst_n && sel_vld && load_en;

    ptr_d        = ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    xfer_count_d = xfer_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      xfer_count_d = xfer_count_q + 32'd1;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(sel_idx)*WIDTH +: WIDTH];
      out_src_d   = sel_idx;
      if (mode) begin
        ptr_d = win + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      xfer_count_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_pipelined_mux_arbiter.sv
// tb_pipelined_mux_arbiter
//   Directed-vector bench for pipelined_mux_arbiter (WIDTH=32, NUM_IN=4).
module tb_pipelined_mux_arbiter;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    mode;
  logic [1:0]              sel;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_src;
  logic                    out_ready;
  logic [31:0]             xfer_count;

  int unsigned n_tests;
  int unsigned n_fail;

  pipelined_mux_arbiter #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state, with valid inputs present to show in_ready is blocked
    #2 rst_n = 1'b0;
    in_valid = 4'hF;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_src", 64'(out_src), 64'd0);
    check_eq("rst_xfer", 64'(xfer_count), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    #9 rst_n = 1'b1;  // released at t=12, between edges

    // Mode 0 sweep: channel k carries 2**k
    for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = 32'(1) << k;
    out_ready = 1'b1;
    for (int s = 0; s < NUM_IN; s++) begin
      sel = 2'(s);
      #1;
      check_eq("m0_in_ready", 64'(in_ready), 64'(4'b0001 << s));
      tick();
      check_eq("m0_out_data", 64'(out_data), 64'(32'(1) << s));
      check_eq("m0_out_src", 64'(out_src), 64'(s));
      check_eq("m0_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = '0;
    tick();
    check_eq("m0_drain_valid", 64'(out_valid), 64'd0);
    check_eq("m0_xfer", 64'(xfer_count), 64'd4);

    // Mode 1, all valid: src 0,1,2,3,0
    mode     = 1'b1;
    in_valid = 4'hF;
    begin
      logic [1:0] exp_src [5];
      exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int b = 0; b < 5; b++) begin
        tick();
        check_eq("rr_out_src", 64'(out_src), 64'(exp_src[b]));
        check_eq("rr_out_data", 64'(out_data), 64'(32'(1) << exp_src[b]));
      end
    end
    in_valid = '0;
    tick();
    check_eq("rr_xfer", 64'(xfer_count), 64'd9);
    check_eq("rr_drain_valid", 64'(out_valid), 64'd0);

    // Reset mid-stall: pointer is 1 here, so ch1 is loaded and held
    out_ready = 1'b0;
    in_valid  = 4'hF;
    tick();
    check_eq("stall_pre_valid", 64'(out_valid), 64'd1);
    check_eq("stall_pre_src", 64'(out_src), 64'd1);
    in_valid = '0;
    tick();
    #2 rst_n = 1'b0;
    in_valid = 4'hF;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_out_data", 64'(out_data), 64'd0);
    check_eq("arst_xfer", 64'(xfer_count), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #2;
    in_valid  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    check_eq("arst_no_stale", 64'(out_valid), 64'd0);
    check_eq("arst_xfer_post", 64'(xfer_count), 64'd0);

    // Mode 1, in_valid=1010 from ptr=0: winners 1,3,1
    mode     = 1'b1;
    in_valid = 4'b1010;
    #1;
    check_eq("sp_ready0", 64'(in_ready), 64'b0010);
    tick();
    check_eq("sp_src0", 64'(out_src), 64'd1);
    check_eq("sp_ready1", 64'(in_ready), 64'b1000);
    tick();
    check_eq("sp_src1", 64'(out_src), 64'd3);
    check_eq("sp_ready2", 64'(in_ready), 64'b0010);
    tick();
    check_eq("sp_src2", 64'(out_src), 64'd1);
    in_valid = '0;
    tick();
    check_eq("sp_xfer", 64'(xfer_count), 64'd3);

    // Held beat from ch2 under backpressure while inputs/sel/mode churn
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    in_data[2*WIDTH +: WIDTH] = 32'hAAAA_5555;
    out_ready = 1'b0;
    #1;
    check_eq("hold_ready_pre", 64'(in_ready), 64'b0100);
    tick();
    check_eq("hold_load_data", 64'(out_data), 64'hAAAA_5555);
    for (int c = 0; c < 3; c++) begin
      in_valid = 4'hF;
      sel      = 2'(c);
      mode     = c[0];
      in_data[2*WIDTH +: WIDTH] = 32'h1000 + 32'(c);
      #1;
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
      check_eq("hold_data", 64'(out_data), 64'hAAAA_5555);
      check_eq("hold_src", 64'(out_src), 64'd2);
      check_eq("hold_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    check_eq("hold_done_valid", 64'(out_valid), 64'd0);
    check_eq("hold_xfer", 64'(xfer_count), 64'd4);

    // Counter wrap: preload all-ones, then complete one transfer
    force dut.xfer_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.xfer_count_q;
    #1;
    check_eq("wrap_preload", 64'(xfer_count), 64'hFFFF_FFFF);
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'b0001;
    tick();
    check_eq("wrap_load_valid", 64'(out_valid), 64'd1);
    in_valid = '0;
    tick();
    check_eq("wrap_xfer", 64'(xfer_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
